// File: rtl/dma_arbiter.sv
// Round-robin TileLink-UH arbiter that shares one DMA device port between
// several DMA-capable hosts. The A channel is granted to one host at a time
// and stays locked for a whole multi-beat Put burst. D responses are routed
// back to the issuing host by the index bits prepended to the A source.
//
// Optional feature macro: DMA_ARB_CREDIT_EN
//   When defined, every host has an outstanding-request credit counter and a
//   host holding MaxOutstanding credits is excluded from arbitration.
module dma_arbiter #(
    parameter int NumHosts        = 2,
    parameter int DataWidth       = 128,
    parameter int AddrWidth       = 38,
    parameter int HostSourceWidth = 3,
    parameter int MaxSize         = 6,
    parameter int MaxOutstanding  = 4,
    parameter int SinkWidth       = 1,
    localparam int IdxW           = (NumHosts > 1) ? $clog2(NumHosts) : 1,
    localparam int DevSourceWidth = HostSourceWidth + IdxW,
    localparam int BeatW          = $clog2((2 ** MaxSize) / (DataWidth / 8)) + 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    // Host A channels
    input  logic [NumHosts-1:0]                         host_a_valid_i,
    output logic [NumHosts-1:0]                         host_a_ready_o,
    input  logic [NumHosts-1:0][2:0]                    host_a_opcode_i,
    input  logic [NumHosts-1:0][2:0]                    host_a_param_i,
    input  logic [NumHosts-1:0][2:0]                    host_a_size_i,
    input  logic [NumHosts-1:0][HostSourceWidth-1:0]    host_a_source_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]          host_a_address_i,
    input  logic [NumHosts-1:0][DataWidth/8-1:0]        host_a_mask_i,
    input  logic [NumHosts-1:0][DataWidth-1:0]          host_a_data_i,
    // Host D channels (fields broadcast)
    output logic [NumHosts-1:0]                         host_d_valid_o,
    input  logic [NumHosts-1:0]                         host_d_ready_i,
    output logic [2:0]                                  host_d_opcode_o,
    output logic [1:0]                                  host_d_param_o,
    output logic [2:0]                                  host_d_size_o,
    output logic [HostSourceWidth-1:0]                  host_d_source_o,
    output logic [SinkWidth-1:0]                        host_d_sink_o,
    output logic                                        host_d_denied_o,
    output logic                                        host_d_corrupt_o,
    output logic [DataWidth-1:0]                        host_d_data_o,
    // Device A channel
    output logic                                        dev_a_valid_o,
    input  logic                                        dev_a_ready_i,
    output logic [2:0]                                  dev_a_opcode_o,
    output logic [2:0]                                  dev_a_param_o,
    output logic [2:0]                                  dev_a_size_o,
    output logic [DevSourceWidth-1:0]                   dev_a_source_o,
    output logic [AddrWidth-1:0]                        dev_a_address_o,
    output logic [DataWidth/8-1:0]                      dev_a_mask_o,
    output logic [DataWidth-1:0]                        dev_a_data_o,
    // Device D channel
    input  logic                                        dev_d_valid_i,
    output logic                                        dev_d_ready_o,
    input  logic [2:0]                                  dev_d_opcode_i,
    input  logic [1:0]                                  dev_d_param_i,
    input  logic [2:0]                                  dev_d_size_i,
    input  logic [DevSourceWidth-1:0]                   dev_d_source_i,
    input  logic [SinkWidth-1:0]                        dev_d_sink_i,
    input  logic                                        dev_d_denied_i,
    input  logic                                        dev_d_corrupt_i,
    input  logic [DataWidth-1:0]                        dev_d_data_i
);

    localparam int ByteLg = $clog2(DataWidth / 8);

    // Reject configurations outside the supported range at elaboration.
    if (NumHosts < 2 || NumHosts > 8 || MaxOutstanding < 1) begin : g_param_check
        $error("dma_arbiter: unsupported NumHosts/MaxOutstanding");
    end

    // Number of data beats carried by a message of the given log2 size.
    // Sizes too large for the beat counter collapse to a single beat.
    function automatic logic [BeatW-1:0] beats_of(input logic [2:0] size);
        logic [BeatW-1:0] n;
        if (int'(size) <= ByteLg) begin
            n = BeatW'(1);
        end else begin
            n = BeatW'(1) << (int'(size) - ByteLg);
        end
        if (n == '0) begin
            n = BeatW'(1);
        end else begin
            n = n;
        end
        return n;
    endfunction

    logic                 r_lock;
    logic [IdxW-1:0]      r_grant;
    logic [IdxW-1:0]      r_rr_ptr;
    logic [BeatW-1:0]     r_a_beats;
    logic                 r_hold;
    logic [IdxW-1:0]      r_hold_idx;

    logic [NumHosts-1:0]  w_elig;
    logic [IdxW-1:0]      w_pick;
    logic                 w_found;
    logic [IdxW-1:0]      w_winner;
    logic                 w_win_valid;
    logic                 w_a_fire;
    logic [BeatW-1:0]     w_a_total;
    logic                 w_a_last;
    logic [IdxW-1:0]      w_rr_next;
    logic [IdxW-1:0]      w_d_idx;
    logic                 w_d_in_range;
    logic                 w_d_fire;

    // Round-robin search: first eligible host at or after r_rr_ptr.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        for (int k = NumHosts - 1; k >= 0; k--) begin
            w_pick  = w_elig[(int'(r_rr_ptr) + k) % NumHosts] ?
                      IdxW'((int'(r_rr_ptr) + k) % NumHosts) : w_pick;
            w_found = w_found | w_elig[(int'(r_rr_ptr) + k) % NumHosts];
        end
    end

    // Winner priority: burst lock, then a stalled presentation, then round-robin.
    always_comb begin
        w_winner    = w_pick;
        w_win_valid = w_found;
        if (r_lock) begin
            w_winner    = r_grant;
            w_win_valid = host_a_valid_i[r_grant];
        end else if (r_hold) begin
            w_winner    = r_hold_idx;
            w_win_valid = host_a_valid_i[r_hold_idx];
        end else begin
            w_winner    = w_pick;
            w_win_valid = w_found;
        end
    end

    assign dev_a_valid_o   = rst_ni & w_win_valid;
    assign dev_a_opcode_o  = host_a_opcode_i[w_winner];
    assign dev_a_param_o   = host_a_param_i[w_winner];
    assign dev_a_size_o    = host_a_size_i[w_winner];
    assign dev_a_source_o  = {w_winner, host_a_source_i[w_winner]};
    assign dev_a_address_o = host_a_address_i[w_winner];
    assign dev_a_mask_o    = host_a_mask_i[w_winner];
    assign dev_a_data_o    = host_a_data_i[w_winner];
    assign w_a_fire        = dev_a_valid_o & dev_a_ready_i;

    // Only the presenting winner sees the device ready.
    always_comb begin
        host_a_ready_o = '0;
        if (rst_ni && dev_a_ready_i && w_win_valid) begin
            host_a_ready_o[w_winner] = 1'b1;
        end else begin
            host_a_ready_o = '0;
        end
    end

    // Beat count of the message currently on the A bus; only Puts carry data.
    always_comb begin
        w_a_total = BeatW'(1);
        if (dev_a_opcode_o == 3'd0 || dev_a_opcode_o == 3'd1) begin
            w_a_total = beats_of(dev_a_size_o);
        end else begin
            w_a_total = BeatW'(1);
        end
    end

    assign w_a_last  = r_lock ? (r_a_beats == BeatW'(1)) : (w_a_total <= BeatW'(1));
    assign w_rr_next = (int'(w_winner) == NumHosts - 1) ? '0 : (w_winner + IdxW'(1));

    // Burst lock, remaining-beat counter and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock    <= 1'b0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_a_beats <= '0;
        end else if (w_a_fire) begin
            if (w_a_last) begin
                r_lock    <= 1'b0;
                r_a_beats <= '0;
                r_rr_ptr  <= w_rr_next;
            end else if (r_lock) begin
                r_a_beats <= r_a_beats - BeatW'(1);
            end else begin
                r_lock    <= 1'b1;
                r_grant   <= w_winner;
                r_a_beats <= w_a_total - BeatW'(1);
            end
        end
    end

    // Keep a presented but unaccepted request on the bus until its handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            r_hold     <= dev_a_valid_o & ~dev_a_ready_i;
            r_hold_idx <= w_winner;
        end
    end

    // D routing: the top IdxW source bits select the host; the rest go back.
    assign w_d_idx          = dev_d_source_i[DevSourceWidth-1 -: IdxW];
    assign w_d_in_range     = ({1'b0, w_d_idx} < (IdxW + 1)'(NumHosts));
    assign w_d_fire         = dev_d_valid_i & dev_d_ready_o;
    assign host_d_opcode_o  = dev_d_opcode_i;
    assign host_d_param_o   = dev_d_param_i;
    assign host_d_size_o    = dev_d_size_i;
    assign host_d_source_o  = dev_d_source_i[HostSourceWidth-1:0];
    assign host_d_sink_o    = dev_d_sink_i;
    assign host_d_denied_o  = dev_d_denied_i;
    assign host_d_corrupt_o = dev_d_corrupt_i;
    assign host_d_data_o    = dev_d_data_i;

    // Steer D valid to the tagged host; beats with no such host are sunk.
    always_comb begin
        host_d_valid_o = '0;
        dev_d_ready_o  = 1'b0;
        if (rst_ni && w_d_in_range) begin
            host_d_valid_o[w_d_idx] = dev_d_valid_i;
            dev_d_ready_o           = host_d_ready_i[w_d_idx];
        end else begin
            dev_d_ready_o = rst_ni;
        end
    end

`ifdef DMA_ARB_CREDIT_EN
    localparam int CW = $clog2(MaxOutstanding + 1);

    logic [NumHosts-1:0][CW-1:0] r_credit;
    logic [BeatW-1:0]            r_d_beats;
    logic [BeatW-1:0]            w_d_total;
    logic                        w_d_last;
    logic [NumHosts-1:0]         w_cr_inc;
    logic [NumHosts-1:0]         w_cr_dec;

    // Hosts with a full credit budget drop out of the round-robin search.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NumHosts; i++) begin
            w_elig[i] = host_a_valid_i[i] & (r_credit[i] != CW'(MaxOutstanding));
        end
    end

    // Beat count of the D message; only AccessAckData carries data.
    always_comb begin
        w_d_total = BeatW'(1);
        if (dev_d_opcode_i == 3'd1) begin
            w_d_total = beats_of(dev_d_size_i);
        end else begin
            w_d_total = BeatW'(1);
        end
    end

    assign w_d_last = (r_d_beats == '0) ? (w_d_total <= BeatW'(1)) : (r_d_beats == BeatW'(1));

    // Remaining D beats of the response in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_d_beats <= '0;
        end else if (w_d_fire) begin
            if (w_d_last) begin
                r_d_beats <= '0;
            end else if (r_d_beats == '0) begin
                r_d_beats <= w_d_total - BeatW'(1);
            end else begin
                r_d_beats <= r_d_beats - BeatW'(1);
            end
        end
    end

    // Credit events: first A beat accepted, last D beat delivered.
    always_comb begin
        w_cr_inc = '0;
        w_cr_dec = '0;
        for (int i = 0; i < NumHosts; i++) begin
            w_cr_inc[i] = w_a_fire & ~r_lock & (int'(w_winner) == i);
            w_cr_dec[i] = w_d_fire & w_d_last & w_d_in_range &
                          (int'(w_d_idx) == i) & (r_credit[i] != '0);
        end
    end

    // Per-host outstanding counters; simultaneous inc and dec cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credit <= '0;
        end else begin
            for (int i = 0; i < NumHosts; i++) begin
                case ({w_cr_inc[i], w_cr_dec[i]})
                    2'b10:   r_credit[i] <= r_credit[i] + CW'(1);
                    2'b01:   r_credit[i] <= r_credit[i] - CW'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end
        end
    end
`else
    assign w_elig = host_a_valid_i;
`endif

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed self-checking bench for dma_arbiter (2 hosts, 128-bit data).
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge. With DMA_ARB_CREDIT_EN the DUT uses MaxOutstanding=2.
module tb_dma_arbiter;

`ifdef DMA_ARB_CREDIT_EN
    localparam int MaxOut = 2;
`else
    localparam int MaxOut = 4;
`endif

    logic               clk_i;
    logic               rst_ni;
    logic [1:0]         h_av, h_ar;
    logic [1:0][2:0]    h_op, h_pa, h_sz, h_src;
    logic [1:0][37:0]   h_addr;
    logic [1:0][15:0]   h_mask;
    logic [1:0][127:0]  h_data;
    logic [1:0]         h_dv, h_dr;
    logic [2:0]         hd_op, hd_sz, hd_src;
    logic [1:0]         hd_pa;
    logic [0:0]         hd_sink;
    logic               hd_den, hd_cor;
    logic [127:0]       hd_data;
    logic               da_v, da_r;
    logic [2:0]         da_op, da_pa, da_sz;
    logic [3:0]         da_src;
    logic [37:0]        da_addr;
    logic [15:0]        da_mask;
    logic [127:0]       da_data;
    logic               dd_v, dd_r;
    logic [2:0]         dd_op, dd_sz;
    logic [1:0]         dd_pa;
    logic [3:0]         dd_src;
    logic [0:0]         dd_sink;
    logic               dd_den, dd_cor;
    logic [127:0]       dd_data;

    int n_cmp = 0;
    int n_bad = 0;

    dma_arbiter #(
        .NumHosts(2), .DataWidth(128), .AddrWidth(38), .HostSourceWidth(3),
        .MaxSize(6), .MaxOutstanding(MaxOut), .SinkWidth(1)
    ) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_a_valid_i(h_av), .host_a_ready_o(h_ar),
        .host_a_opcode_i(h_op), .host_a_param_i(h_pa), .host_a_size_i(h_sz),
        .host_a_source_i(h_src), .host_a_address_i(h_addr),
        .host_a_mask_i(h_mask), .host_a_data_i(h_data),
        .host_d_valid_o(h_dv), .host_d_ready_i(h_dr),
        .host_d_opcode_o(hd_op), .host_d_param_o(hd_pa), .host_d_size_o(hd_sz),
        .host_d_source_o(hd_src), .host_d_sink_o(hd_sink),
        .host_d_denied_o(hd_den), .host_d_corrupt_o(hd_cor), .host_d_data_o(hd_data),
        .dev_a_valid_o(da_v), .dev_a_ready_i(da_r),
        .dev_a_opcode_o(da_op), .dev_a_param_o(da_pa), .dev_a_size_o(da_sz),
        .dev_a_source_o(da_src), .dev_a_address_o(da_addr),
        .dev_a_mask_o(da_mask), .dev_a_data_o(da_data),
        .dev_d_valid_i(dd_v), .dev_d_ready_o(dd_r),
        .dev_d_opcode_i(dd_op), .dev_d_param_i(dd_pa), .dev_d_size_i(dd_sz),
        .dev_d_source_i(dd_src), .dev_d_sink_i(dd_sink),
        .dev_d_denied_i(dd_den), .dev_d_corrupt_i(dd_cor), .dev_d_data_i(dd_data)
    );

    // Free-running clock, 10 time units per period.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic set_a(input int h, input logic v, input logic [2:0] op,
                         input logic [2:0] sz, input logic [2:0] src,
                         input logic [37:0] addr, input logic [127:0] data);
        h_av[h]   = v;
        h_op[h]   = op;
        h_sz[h]   = sz;
        h_src[h]  = src;
        h_addr[h] = addr;
        h_data[h] = data;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        h_av   = 2'b00;
        dd_v   = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        adv();
    endtask

    initial begin
        rst_ni = 1'b0;
        h_av = 2'b11; h_op = '0; h_pa = '0; h_sz = '0; h_src = '0;
        h_addr = '0; h_mask = '1; h_data = '0; h_dr = 2'b11;
        da_r = 1'b1;
        dd_v = 1'b1; dd_op = 3'd0; dd_pa = 2'd0; dd_sz = 3'd3; dd_src = 4'd0;
        dd_sink = 1'b0; dd_den = 1'b0; dd_cor = 1'b0; dd_data = '0;

        // Reset holds every handshake output low even with live inputs.
        #3;
        chk("rst_dev_a_valid", 64'(da_v), 64'd0);
        chk("rst_host_a_ready", 64'(h_ar), 64'd0);
        chk("rst_host_d_valid", 64'(h_dv), 64'd0);
        chk("rst_dev_d_ready", 64'(dd_r), 64'd0);
        h_av = 2'b00; dd_v = 1'b0; h_dr = 2'b00;
        @(negedge clk_i);
        rst_ni = 1'b1;
        adv();

        // Two hosts issuing single-beat Gets alternate 0,1,0,1.
        set_a(0, 1'b1, 3'd4, 3'd3, 3'd2, 38'h100, 128'h0);
        set_a(1, 1'b1, 3'd4, 3'd3, 3'd6, 38'h200, 128'h0);
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("get_rr_ready", 64'(h_ar), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("get_rr_source", 64'(da_src), (k % 2 == 0) ? 64'd2 : 64'd14);
            chk("get_rr_addr", 64'(da_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            adv();
        end

        // 4-beat PutFullData from host0 is not interleaved with host1.
        do_reset();
        set_a(1, 1'b1, 3'd4, 3'd3, 3'd6, 38'h200, 128'h0);
        for (int b = 0; b < 4; b++) begin
            set_a(0, 1'b1, 3'd0, 3'd6, 3'd1, 38'h400, 128'(b + 8'hA0));
            settle();
            chk("put_lock_ready", 64'(h_ar), 64'd1);
            chk("put_lock_data", 64'(da_data[7:0]), 64'(b + 8'hA0));
            adv();
        end
        h_av[0] = 1'b0;
        settle();
        chk("put_after_ready", 64'(h_ar), 64'd2);
        chk("put_after_source", 64'(da_src), 64'd14);
        adv();
        h_av = 2'b00;

        // Device stall: presented host0 stays on the bus although the pointer
        // already favours host1 once it raises valid.
        do_reset();
        set_a(0, 1'b1, 3'd4, 3'd3, 3'd2, 38'h100, 128'h0);
        settle();
        chk("stall_pre_ready", 64'(h_ar), 64'd1);
        adv();
        da_r = 1'b0;
        set_a(0, 1'b1, 3'd4, 3'd3, 3'd2, 38'h300, 128'h0);
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_valid", 64'(da_v), 64'd1);
            chk("stall_source", 64'(da_src), 64'd2);
            chk("stall_addr", 64'(da_addr), 64'h300);
            chk("stall_ready", 64'(h_ar), 64'd0);
            adv();
            set_a(1, 1'b1, 3'd4, 3'd3, 3'd6, 38'h200, 128'h0);
        end
        da_r = 1'b1;
        settle();
        chk("stall_accept_ready", 64'(h_ar), 64'd1);
        chk("stall_accept_addr", 64'(da_addr), 64'h300);
        adv();
        h_av[0] = 1'b0;
        settle();
        chk("stall_next_ready", 64'(h_ar), 64'd2);
        chk("stall_next_source", 64'(da_src), 64'd14);
        adv();
        h_av = 2'b00;

        // D routing: AccessAckData to {1,5} reaches only host1 with source 5.
        do_reset();
        dd_v = 1'b1; dd_op = 3'd1; dd_sz = 3'd6; dd_src = 4'b1101; h_dr = 2'b10;
        for (int b = 0; b < 4; b++) begin
            dd_data = 128'(b + 8'h50);
            settle();
            chk("d_route_valid", 64'(h_dv), 64'd2);
            chk("d_route_ready", 64'(dd_r), 64'd1);
            chk("d_route_source", 64'(hd_src), 64'd5);
            chk("d_route_data", 64'(hd_data[7:0]), 64'(b + 8'h50));
            adv();
        end
        dd_op = 3'd0; dd_sz = 3'd3; h_dr = 2'b00;
        settle();
        chk("d_backpress_ready", 64'(dd_r), 64'd0);
        chk("d_backpress_valid", 64'(h_dv), 64'd2);
        adv();
        dd_src = 4'b0001; h_dr = 2'b01;
        settle();
        chk("d_host0_valid", 64'(h_dv), 64'd1);
        chk("d_host0_source", 64'(hd_src), 64'd1);
        chk("d_host0_ready", 64'(dd_r), 64'd1);
        adv();
        dd_v = 1'b0;

        // Reset during beat 2 of a host1 burst clears lock and pointer.
        do_reset();
        set_a(0, 1'b1, 3'd4, 3'd3, 3'd2, 38'h100, 128'h0);
        settle();
        chk("rstb_pre_ready", 64'(h_ar), 64'd1);
        adv();
        set_a(1, 1'b1, 3'd0, 3'd6, 3'd3, 38'h800, 128'h0);
        for (int b = 0; b < 2; b++) begin
            settle();
            chk("rstb_burst_ready", 64'(h_ar), 64'd2);
            chk("rstb_burst_source", 64'(da_src), 64'd11);
            adv();
        end
        dd_v = 1'b1; dd_src = 4'b0000; h_dr = 2'b11;
        rst_ni = 1'b0;
        #1;
        chk("rstb_dev_a_valid", 64'(da_v), 64'd0);
        chk("rstb_host_a_ready", 64'(h_ar), 64'd0);
        chk("rstb_host_d_valid", 64'(h_dv), 64'd0);
        chk("rstb_dev_d_ready", 64'(dd_r), 64'd0);
        dd_v = 1'b0; h_dr = 2'b00;
        set_a(1, 1'b1, 3'd4, 3'd3, 3'd3, 38'h800, 128'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rstb_after_ready", 64'(h_ar), 64'd1);
        chk("rstb_after_source", 64'(da_src), 64'd2);
        adv();
        h_av = 2'b00;

`ifdef DMA_ARB_CREDIT_EN
        // Host0 at its credit limit is skipped until a response returns.
        do_reset();
        set_a(0, 1'b1, 3'd4, 3'd3, 3'd2, 38'h100, 128'h0);
        for (int g = 0; g < 2; g++) begin
            settle();
            chk("cr_get_ready", 64'(h_ar), 64'd1);
            adv();
        end
        set_a(1, 1'b1, 3'd4, 3'd3, 3'd6, 38'h200, 128'h0);
        settle();
        chk("cr_block_ready", 64'(h_ar), 64'd2);
        chk("cr_block_source", 64'(da_src), 64'd14);
        adv();
        h_av[1] = 1'b0;
        dd_v = 1'b1; dd_op = 3'd1; dd_sz = 3'd3; dd_src = 4'b0010; h_dr = 2'b01;
        settle();
        chk("cr_excluded_valid", 64'(da_v), 64'd0);
        chk("cr_excluded_ready", 64'(h_ar), 64'd0);
        chk("cr_resp_valid", 64'(h_dv), 64'd1);
        adv();
        dd_v = 1'b0; h_dr = 2'b00;
        settle();
        chk("cr_resume_ready", 64'(h_ar), 64'd1);
        adv();
        h_av = 2'b00;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Round-robin TileLink-UH arbiter that shares the single coherent DMA port (dma_tl into ccx) between several DMA-capable peripherals (Ethernet, SDHCI, future masters).
- A channel: grant one host at a time, locked for the whole multi-beat Put burst.
- D channel: routed back to the issuing host by source-ID tag bits the arbiter prepends on the A path.
- Only A and D channels; B/C/E are tied off by the instantiator.

Parameters:
- NumHosts, 2, number of DMA requesters (2..8)
- DataWidth, 128, bus data width in bits
- AddrWidth, 38, address width
- HostSourceWidth, 3, source width of each host port
- MaxSize, 6, log2 of the largest transfer in bytes
- MaxOutstanding, 4, per-host outstanding request limit (only with DMA_ARB_CREDIT_EN)
- Derived parameters:
  - IdxW = max(1, clog2(NumHosts))
  - DevSourceWidth = HostSourceWidth + IdxW
  - BeatW = clog2(2^MaxSize / (DataWidth/8)) + 1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- host_a_valid_i  in  NumHosts  per-host A valid
- host_a_ready_o  out  NumHosts  per-host A ready
- host_a_opcode_i/param_i/size_i  in  NumHosts x 3 each  per-host A fields
- host_a_source_i  in  NumHosts x HostSourceWidth  per-host A source
- host_a_address_i  in  NumHosts x AddrWidth  per-host A address
- host_a_mask_i  in  NumHosts x DataWidth/8  per-host A mask
- host_a_data_i  in  NumHosts x DataWidth  per-host A data
- host_d_valid_o  out  NumHosts  per-host D valid
- host_d_ready_i  in  NumHosts  per-host D ready
- host_d_opcode_o/param_o/size_o/source_o/sink_o/denied_o/corrupt_o/data_o  out  broadcast  D fields, identical to device D (source_o stripped of tag)
- dev_a_valid_o/dev_a_ready_i, dev_a_* fields  out/in  device A; source is DevSourceWidth = {host index, host source}
- dev_d_valid_i/dev_d_ready_o, dev_d_* fields  in/out  device D

Behaviour:
- Reset state: lock=0, grant=0, rr_ptr=0, beat counters=0, credits=0. dev_a_valid_o=0, host_a_ready_o=0, host_d_valid_o=0, dev_d_ready_o=0 while rst_ni low.
- Beats per A message:
  - PutFullData(0) / PutPartialData(1): max(1, 2^size / (DataWidth/8)).
  - All other opcodes: 1.
- Beats per D message:
  - AccessAckData(1): same formula.
  - All other opcodes: 1.
- A arbitration is combinational, zero added latency:
  - When unlocked, the winner is the first valid host at or after rr_ptr (cyclic).
  - dev_a_valid_o = host_a_valid_i[winner]; dev_a fields mux from the winner; dev_a_source_o = {winner, host source}.
  - host_a_ready_o[i] = dev_a_ready_i && i==winner. Non-winners see ready 0.
- Burst lock:
  - On an accepted first beat of a multi-beat message: lock=1, grant=winner, a_beats = total-1.
  - While locked, winner=grant regardless of other valids. Each accepted beat decrements a_beats.
  - The beat that reaches 0 clears lock.
- rr_ptr update:
  - rr_ptr = (winner+1) mod NumHosts on acceptance of the last beat of any message (a single-beat message counts as last).
  - rr_ptr is unchanged on intermediate beats.
- A valid already presented to the device must not be withdrawn by arbitration. If dev_a_valid_o=1 and dev_a_ready_i=0, the winner is held (registered hold flag) until handshake.
- D routing:
  - Target host = dev_d_source_i[DevSourceWidth-1 -: IdxW]; host_d_valid_o[target] = dev_d_valid_i; dev_d_ready_o = host_d_ready_i[target].
  - Out-of-range index (NumHosts not a power of 2): the beat is dropped (dev_d_ready_o=1, no host valid).
- Simultaneous A and D handshakes in the same cycle are independent.
- Reset mid-burst aborts the lock. Recovery of the hosts and device is the system's responsibility.

Optional Feature:
- Macro: DMA_ARB_CREDIT_EN.
- When defined:
  - Per-host credit counter, width clog2(MaxOutstanding+1).
  - Incremented on acceptance of the first A beat of a message; decremented on the last D beat to that host.
  - Same-cycle inc+dec leaves the counter unchanged.
  - A host with credit==MaxOutstanding is excluded from arbitration (treated as not valid) unless it currently holds the lock.
- When undefined: no counters and no exclusion; the arbiter is purely stateless apart from lock, hold and rr_ptr.

Test Plan:
- Two hosts assert single-beat Get (size 3) every cycle, device always ready -> grants alternate 0,1,0,1; dev_a_source_o = {0,src}, {1,src}.
- Host0 PutFullData size 6 (4 beats at 128-bit) while host1 is valid throughout -> 4 consecutive host0 beats with no host1 beat interleaved; host1 granted on cycle 5.
- Device holds dev_a_ready_i=0 for 3 cycles with host0 presented and host1 raising valid -> dev_a fields stable, host0 accepted on cycle 4, host1 next.
- Device returns AccessAckData size 6, source {1,3'd5} -> only host_d_valid_o[1] asserted for 4 beats with source_o=5; host1 backpressure (ready 0) stalls dev_d_ready_o.
- Reset asserted during beat 2 of a 4-beat Put -> all outputs 0 immediately. After release, the next request arbitrates from rr_ptr=0 with lock clear.
- With DMA_ARB_CREDIT_EN and MaxOutstanding=2: host0 issues 3 Gets with no responses -> third request blocked and host1 still served; one AccessAckData to host0 -> third Get is accepted the following cycle.
